// File: rtl/head_prune_sched_pkg.sv
// Shared definitions for the per-head prune sequencer: state encoding and
// default head/tile counts used by the mean stage and the sequencer.
package head_prune_sched_pkg;

    localparam int DEF_NUM_HEADS      = 4;
    localparam int DEF_TILES_PER_HEAD = 2;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLEAR   = 4'd1,
        S_ACCUM   = 4'd2,
        S_SETTLE  = 4'd3,
        S_COMPARE = 4'd4,
        S_LAUNCH  = 4'd5,
        S_WAIT_SV = 4'd6,
        S_NEXT    = 4'd7,
        S_DONE    = 4'd8
    } state_e;

endpackage

// File: rtl/head_prune_sched.sv
// Per-head sequencer: gates tile pairs into the mean stage, captures the prune
// decision, and launches softmax*V only for heads that are kept.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; mask/count from last pass held
// CLEAR   | mean accumulator cleared for one cycle
// ACCUM   | absorbing TILES_PER_HEAD tile-pair beats
// SETTLE  | mean stage registered sums update
// COMPARE | compare strobe; PruneHead captured into the mask
// LAUNCH  | sv_start pulse for a kept head
// WAIT_SV | waiting for sv_done
// NEXT    | advance head or finish
// DONE    | done pulse
module head_prune_sched
    import head_prune_sched_pkg::*;
#(
    parameter int NUM_HEADS      = DEF_NUM_HEADS,
    parameter int TILES_PER_HEAD = DEF_TILES_PER_HEAD,
    parameter int HEAD_W         = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tile_valid,
    output logic                 mean_clear_n,
    output logic                 mean_enable,
    output logic                 mean_compare_flag,
    input  logic                 prune_head_in,
    output logic                 sv_start,
    input  logic                 sv_done,
    output logic [HEAD_W-1:0]    head_idx,
    output logic [NUM_HEADS-1:0] prune_mask,
    output logic [HEAD_W:0]      kept_count,
    output logic                 busy,
    output logic                 done
);

    localparam int TILE_W = $clog2(TILES_PER_HEAD + 1);
    localparam logic [HEAD_W-1:0] LAST_HEAD = HEAD_W'(NUM_HEADS - 1);
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(TILES_PER_HEAD - 1);

    state_e                state_q, state_d;
    logic [HEAD_W-1:0]     head_q, head_d;
    logic [NUM_HEADS-1:0]  mask_q, mask_d;
    logic [HEAD_W:0]       kept_q, kept_d;
    logic [TILE_W-1:0]     tile_q, tile_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            mask_q  <= '0;
            kept_q  <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            mask_q  <= mask_d;
            kept_q  <= kept_d;
            tile_q  <= tile_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        mask_d  = mask_q;
        kept_d  = kept_q;
        tile_d  = tile_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    head_d  = '0;
                    mask_d  = '0;
                    kept_d  = '0;
                end
            end
            S_CLEAR: begin
                tile_d  = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (tile_valid) begin
                    tile_d = tile_q + 1'b1;
                    if (tile_q == LAST_TILE) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: state_d = S_COMPARE;
            S_COMPARE: begin
                mask_d[head_q] = prune_head_in;
                if (prune_head_in) begin
                    state_d = S_NEXT;
                end else begin
                    kept_d  = kept_q + 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            // sv_done in the launch cycle is deliberately not looked at
            S_LAUNCH: state_d = S_WAIT_SV;
            S_WAIT_SV: begin
                if (sv_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (head_q == LAST_HEAD) begin
                    state_d = S_DONE;
                end else begin
                    head_d  = head_q + 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mean_clear_n      = (state_q != S_CLEAR);
        mean_enable       = (state_q == S_ACCUM) && tile_valid;
        mean_compare_flag = (state_q == S_COMPARE);
        sv_start          = (state_q == S_LAUNCH);
        done              = (state_q == S_DONE);
        busy              = (state_q != S_IDLE);
    end

    assign head_idx   = head_q;
    assign prune_mask = mask_q;
    assign kept_count = kept_q;

endmodule

// File: tb/tb_head_prune_sched.sv
// Self-checking bench for head_prune_sched: table of passes driven by a
// reactive loop, with a queue of expected sv_start heads.
module tb_head_prune_sched;

    localparam int NH  = 4;
    localparam int TPH = 2;
    localparam int HW  = 2;

    logic          clk = 1'b0;
    logic          reset, start, tile_valid, prune_head_in, sv_done;
    logic          mean_clear_n, mean_enable, mean_compare_flag, sv_start;
    logic [HW-1:0] head_idx;
    logic [NH-1:0] prune_mask;
    logic [HW:0]   kept_count;
    logic          busy, done;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    head_prune_sched #(.NUM_HEADS(NH), .TILES_PER_HEAD(TPH), .HEAD_W(HW)) dut (
        .clk(clk), .reset(reset), .start(start), .tile_valid(tile_valid),
        .mean_clear_n(mean_clear_n), .mean_enable(mean_enable),
        .mean_compare_flag(mean_compare_flag), .prune_head_in(prune_head_in),
        .sv_start(sv_start), .sv_done(sv_done), .head_idx(head_idx),
        .prune_mask(prune_mask), .kept_count(kept_count), .busy(busy), .done(done)
    );

    typedef struct {
        logic [NH-1:0] pat;
        int            gap;
        int            lat;
        bit            spur;
        int            abort_head;
        logic [NH-1:0] exp_mask;
        int            exp_kept;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_head_idx"}, int'(head_idx), 0);
        chk({tag, "_prune_mask"}, int'(prune_mask), 0);
        chk({tag, "_kept_count"}, int'(kept_count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_sv_start"}, int'(sv_start), 0);
        chk({tag, "_mean_enable"}, int'(mean_enable), 0);
        chk({tag, "_compare_flag"}, int'(mean_compare_flag), 0);
        chk({tag, "_mean_clear_n"}, int'(mean_clear_n), 1);
    endtask

    task automatic run_pass(input vec_t v);
        int cyc, sv_cnt, exp_head, en_cnt, last_en, model_cycles;
        bit finished, abort_pend;
        model_cycles = 1;
        for (int h = 0; h < NH; h++) model_cycles += v.pat[h] ? 6 : (7 + v.lat);
        exp_q.delete();
        start = 1'b1; sv_done = 1'b0; prune_head_in = 1'b0;
        tile_valid = (v.gap == 0);
        step();
        cyc = 1; sv_cnt = 0; exp_head = 0; en_cnt = 0; last_en = -100;
        finished = 1'b0; abort_pend = 1'b0;
        while (!finished && cyc < 400) begin
            start = 1'b0; sv_done = 1'b0; prune_head_in = 1'b0;
            tile_valid = (v.gap == 0) ? 1'b1 : ((cyc % (v.gap + 1)) == 0);
            if (sv_cnt > 0) begin
                sv_cnt--;
                if (sv_cnt == 0) sv_done = 1'b1;
            end
            if (abort_pend) begin
                reset = 1'b1;
                step();
                reset = 1'b0; tile_valid = 1'b0; sv_done = 1'b0;
                chk_reset_outputs("abort");
                for (int i = 0; i < 4; i++) begin
                    step();
                    chk("abort_idle_busy", int'(busy), 0);
                    chk("abort_idle_done", int'(done), 0);
                    chk("abort_idle_sv_start", int'(sv_start), 0);
                end
                return;
            end
            if (mean_compare_flag && exp_head < NH) prune_head_in = v.pat[exp_head];
            if (v.spur && (!mean_clear_n || mean_compare_flag)) start = 1'b1;
            if (v.spur && !mean_clear_n) sv_done = 1'b1;
            #1;
            if (mean_enable) begin
                chk("mean_enable_gated", int'(tile_valid), 1);
                en_cnt++;
                last_en = cyc;
            end
            if (mean_compare_flag) begin
                chk("compare_head_idx", int'(head_idx), exp_head);
                chk("tiles_per_head", en_cnt, TPH);
                chk("compare_delay", cyc - last_en, 2);
                if (exp_head < NH && !v.pat[exp_head]) exp_q.push_back(exp_head);
                exp_head++;
                en_cnt = 0;
            end
            if (sv_start) begin
                if (exp_q.size() == 0) chk("sv_start_unexpected", int'(head_idx), -1);
                else chk("sv_start_head", int'(head_idx), exp_q.pop_front());
                sv_cnt = v.lat;
                if (v.spur) sv_done = 1'b1;
                if (int'(head_idx) == v.abort_head) abort_pend = 1'b1;
            end
            if (done) begin
                finished = 1'b1;
                chk("prune_mask", int'(prune_mask), int'(v.exp_mask));
                chk("kept_count", int'(kept_count), v.exp_kept);
                chk("sv_queue_empty", exp_q.size(), 0);
                chk("heads_compared", exp_head, NH);
                if (v.gap == 0) chk("pass_cycles", cyc, model_cycles);
            end
            step();
            cyc++;
        end
        if (!finished) begin
            chk("pass_timeout", cyc, -1);
            return;
        end
        tile_valid = 1'b0; sv_done = 1'b0;
        #1;
        chk("done_single_pulse", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("head_idx_hold", int'(head_idx), NH - 1);
        step();
        chk("mask_hold", int'(prune_mask), int'(v.exp_mask));
        chk("kept_hold", int'(kept_count), v.exp_kept);
    endtask

    initial begin
        vecs[0] = '{4'b0000, 0, 3, 1'b0, -1, 4'b0000, 4};
        vecs[1] = '{4'b1010, 0, 3, 1'b0, -1, 4'b1010, 2};
        vecs[2] = '{4'b1111, 0, 1, 1'b0, -1, 4'b1111, 0};
        vecs[3] = '{4'b0110, 0, 2, 1'b1, -1, 4'b0110, 2};
        vecs[4] = '{4'b0001, 5, 4, 1'b0, -1, 4'b0001, 3};
        vecs[5] = '{4'b0010, 0, 5, 1'b0,  2, 4'b0000, 0};
        vecs[6] = '{4'b1001, 0, 2, 1'b0, -1, 4'b1001, 2};

        reset = 1'b1; start = 1'b0; tile_valid = 1'b0;
        prune_head_in = 1'b0; sv_done = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");

        // start coinciding with reset must be lost
        start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        #1;
        chk("reset_beats_start", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_busy_low", int'(busy), 0);
            chk("idle_no_done", int'(done), 0);
        end

        for (int i = 0; i < 7; i++) run_pass(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/head_prune_sched.md
Name: head_prune_sched

Overview:
- Per-head sequencer directly downstream of the Q*K absolute-sum / prune-decision stage.
- For each of NUM_HEADS heads it:
  - gates tile-pair results into the mean stage (enable);
  - raises the compare flag and captures the prune decision;
  - launches the softmax*V stage only for heads that are kept.
- Builds a per-head prune mask and signals completion to the top-level attention controller.

Parameters:
- NUM_HEADS, 4, heads processed per start.
- TILES_PER_HEAD, 2, tile-pair beats per head (2 beats x 32 results each).
- HEAD_W, 2, width of head index; must satisfy 2^HEAD_W >= NUM_HEADS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a pass over all heads.
- tile_valid  in  1  systolic array presents one tile pair of Q*K results this cycle.
- mean_clear_n  out  1  active-low clear to the mean stage accumulator.
- mean_enable  out  1  mean stage enable (absorb current tile pair).
- mean_compare_flag  out  1  mean stage compare strobe.
- prune_head_in  in  1  mean stage PruneHead, valid combinationally while the compare flag is high.
- sv_start  out  1  one-cycle pulse; run softmax*V for head_idx.
- sv_done  in  1  pulse from softmax*V stage.
- head_idx  out  HEAD_W  head currently processed.
- prune_mask  out  NUM_HEADS  bit h = 1 means head h was pruned.
- kept_count  out  HEAD_W+1  number of heads not pruned in this pass.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset state:
  - state=IDLE;
  - outputs head_idx=0, prune_mask=0, kept_count=0, busy=0, done=0, sv_start=0, mean_enable=0, mean_compare_flag=0, mean_clear_n=1;
  - tile counter=0.
- States:
  - IDLE:
    - start=1 -> CLEAR; on that edge head_idx<=0, prune_mask<=0, kept_count<=0.
    - start while not IDLE is ignored.
  - CLEAR:
    - mean_clear_n=0 for exactly 1 cycle; tile counter<=0 -> ACCUM.
  - ACCUM:
    - mean_enable = tile_valid, combinationally, in the same cycle.
    - Each tile_valid increments the tile counter.
    - When tile_valid arrives with counter == TILES_PER_HEAD-1 -> SETTLE.
    - tile_valid in any other state is ignored; mean_enable=0 outside ACCUM.
  - SETTLE:
    - 1 cycle, so the mean stage's registered absolute values and its sum update -> COMPARE.
  - COMPARE:
    - mean_compare_flag=1 for exactly 1 cycle.
    - prune_head_in is sampled at the end of this cycle into prune_mask[head_idx].
    - prune_head_in=1 -> NEXT.
    - prune_head_in=0 -> LAUNCH, and kept_count increments.
  - LAUNCH:
    - sv_start=1 for 1 cycle -> WAIT_SV.
  - WAIT_SV:
    - Holds until sv_done=1 -> NEXT. There is no timeout.
    - sv_done outside WAIT_SV is ignored.
    - sv_done arriving in the LAUNCH cycle is ignored; the stage must wait at least 1 cycle after sv_start.
  - NEXT:
    - head_idx == NUM_HEADS-1 -> DONE.
    - Otherwise head_idx<=head_idx+1 -> CLEAR.
  - DONE:
    - done=1 for 1 cycle -> IDLE.
    - prune_mask and kept_count hold until the next start.
- head_idx never wraps within a pass. It holds its last value (NUM_HEADS-1) after DONE.
- Latency:
  - fully pruned head: CLEAR + TILES_PER_HEAD valid beats + SETTLE + COMPARE + NEXT.
  - kept head: above + LAUNCH + sv latency.
  - minimum per pruned head = 4 + TILES_PER_HEAD cycles.
- reset asserted mid-pass:
  - next edge forces IDLE with all reset values;
  - no sv_start or done is emitted;
  - mean_clear_n returns to 1.
- start and reset in the same cycle: reset wins.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, CLEAR, ACCUM, SETTLE, COMPARE, LAUNCH, WAIT_SV, NEXT, DONE);
  - defaults NUM_HEADS and TILES_PER_HEAD, reused by the mean stage and the top.
- No sub-module. The tile counter and head counter live inline; a separate counter module adds nothing.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> all outputs at reset values, busy=0, no pulses.
- All heads kept: start, 2 tile_valid per head, prune_head_in=0, sv_done 3 cycles after each sv_start -> 4 sv_start pulses with head_idx 0..3, prune_mask=4'b0000, kept_count=4, done single pulse.
- Mixed pruning: prune_head_in=1 on heads 1 and 3 -> sv_start only for heads 0 and 2, prune_mask=4'b1010, kept_count=2; each pruned head adds exactly 6 cycles.
- Spurious inputs: tile_valid during SETTLE/WAIT_SV, sv_done during ACCUM, start while busy -> ignored; mean_enable stays 0 outside ACCUM; tile count and head sequence unchanged.
- Gapped tiles: tile_valid with 5-cycle gaps -> stays in ACCUM; mean_enable pulses only on valid cycles; mean_compare_flag appears exactly 2 cycles after the 2nd valid.
- Reset mid-op: reset during WAIT_SV for head 2 -> IDLE next edge, prune_mask=0, kept_count=0, no done; a fresh start then completes normally.
